microwave_time_entry: RTL and testbench
=======================================

Name: microwave_time_entry

Overview:
- Keypad-side writer for the microwave MM:SS countdown timer. It collects up to three decimal digits and shifts them in microwave-style (each new digit enters the seconds-units position).
- On start it normalises the entry to valid M:SS and drives the timer's preset digits with a one-cycle load pulse. It then holds the timer's enable until the timer reports done, and finishes with a beep pulse.

Parameters:
- BEEP_CYCLES, 3, number of cycles beep is held high after completion (≥1)
- MAX_DIGITS, 3, number of digits accepted per entry; extra digits are ignored

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe: key_code is valid
- key_code  in  4  digit value 0-9; values 10-15 are ignored
- start  in  1  one-cycle strobe: begin cooking
- clear  in  1  one-cycle strobe: cancel entry or cooking
- timer_done  in  1  timer reached 0:00 (level)
- preset_sec_units  out  4  seconds-units preset to the timer, 0-9
- preset_sec_tens  out  3  seconds-tens preset to the timer, 0-5
- preset_min_units  out  4  minutes preset to the timer, 0-9
- load  out  1  one-cycle load strobe to the timer
- enable  out  1  timer count enable
- beep  out  1  completion indicator
- state  out  3  current FSM state, for display/debug

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE, all outputs 0, internal digits 0, digit count 0.
- All outputs are registered. Input priority in one cycle: clear > start > key_valid.
- Internal entry: three 4-bit raw digits d2:d1:d0 (min, tens, units) and a 2-bit count.
- Key accept (IDLE or ENTRY, key_code ≤ 9, count < MAX_DIGITS):
  - d2 ← d1, d1 ← d0, d0 ← key_code, count++
  - IDLE → ENTRY
- Ignored keys:
  - key_code ≥ 10: no change anywhere.
  - count = MAX_DIGITS: digit dropped, no change.
- Leading zeros count as digits.
- States:
  - IDLE (0): wait for a key.
  - ENTRY (1): accumulate digits.
    - clear → IDLE, digits and count zeroed.
    - start with d2:d1:d0 = 0:00 → ignored, stay in ENTRY.
    - start with nonzero entry → LOAD; the normalised presets register on the same edge.
  - LOAD (2): load=1 for exactly this cycle, presets stable → RUNNING.
    - clear in LOAD → IDLE, load is not repeated.
  - RUNNING (3): enable=1 on every RUNNING cycle. Keys and start are ignored.
    - timer_done=1 → DONE, enable=0 on the next cycle.
    - clear → IDLE, enable=0, presets zeroed.
    - clear and timer_done in the same cycle → IDLE; clear wins.
  - DONE (4): beep=1 for BEEP_CYCLES cycles (internal down-counter), then IDLE with presets and digits zeroed.
    - clear in DONE → IDLE immediately, beep=0.
- timer_done is sampled only in RUNNING; it is ignored in all other states.
- Presets hold their value from LOAD until IDLE is entered.
- Latency: start at edge N → load=1 in cycle N+1 → enable=1 from cycle N+2.
- Normalisation (applied at start):
  - If d1 ≤ 5: preset = d2:d1:d0.
  - If d1 ≥ 6 and d2 ≤ 8: preset = (d2+1):(d1−6):d0.
  - If d1 ≥ 6 and d2 = 9: saturate to 9:59.
  - preset_sec_tens is the low 3 bits of the normalised tens digit, which is always ≤ 5.

Decomposition:
- Shared package (microwave_pkg):
  - state encodings IDLE=0, ENTRY=1, LOAD=2, RUNNING=3, DONE=4
  - constants MAX_SEC_TENS=5, MAX_DIGIT=9
  - digit width 4, tens width 3
- Sub-module time_normalizer: purely combinational d2:d1:d0 → normalised min/tens/units. Instantiated once; its output is registered in the parent on the start edge.

Test Plan:
- Keys 1,3,0 then start → load pulses once with preset 1:30; enable rises one cycle after load; hold timer_done=1 → enable=0, beep=1 for 3 cycles, then state=IDLE.
- Keys 1,7,5 then start → preset 2:15. Keys 9,9,9 then start → preset 9:59 (saturated).
- Keys 4,2,5,8 (fourth dropped) then start → preset 4:25. Key_code=12 mid-entry → no change to digits or count.
- Start with no digits (IDLE), or after keys 0,0 → no load; stays in IDLE or ENTRY respectively.
- In RUNNING: key 5 and start ignored (presets unchanged). Clear asserted together with timer_done → IDLE, beep never asserts, enable=0.
- Assert Reset asynchronously mid-RUNNING (between clock edges) → enable, load, beep and presets read 0 before the next edge; state=IDLE.

Source files
------------

// File: rtl/microwave_pkg.sv
// -----------------------------------------------------------------------------
// microwave_pkg
// Shared definitions for the microwave keypad time-entry block:
//   - FSM state encodings (3-bit, numeric values visible on the state port)
//   - digit/tens field widths and digit limits
//   - preset_t: normalised M:SS preset as handed to the countdown timer
//   - is_digit(): true for a valid decimal key code (0-9)
// -----------------------------------------------------------------------------
package microwave_pkg;

   localparam int DIGIT_W = 4;
   localparam int TENS_W  = 3;
   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_ENTRY   = 3'd1;
   localparam logic [STATE_W-1:0] ST_LOAD    = 3'd2;
   localparam logic [STATE_W-1:0] ST_RUNNING = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

   localparam logic [DIGIT_W-1:0] MAX_DIGIT    = 4'd9;
   localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;

   typedef struct packed {
      logic [DIGIT_W-1:0] min;
      logic [TENS_W-1:0]  tens;
      logic [DIGIT_W-1:0] units;
   } preset_t;

   function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
      return code <= MAX_DIGIT;
   endfunction

endpackage

// File: rtl/time_normalizer.sv
// -----------------------------------------------------------------------------
// time_normalizer
// Purely combinational. Converts the raw keyed digits d2:d1:d0
// (minutes, seconds-tens, seconds-units) into a valid M:SS preset.
//   d2_i, d1_i, d0_i : raw decimal digits, each 0-9
//   preset_o         : normalised minutes / seconds-tens / seconds-units
// A tens digit of 6-9 means the user typed e.g. "90" seconds; the excess
// minute is carried into the minutes digit. If minutes is already 9 the
// carry cannot be represented, so the result saturates to 9:59.
// -----------------------------------------------------------------------------
module time_normalizer
   import microwave_pkg::*;
(
   input  logic [DIGIT_W-1:0] d2_i,
   input  logic [DIGIT_W-1:0] d1_i,
   input  logic [DIGIT_W-1:0] d0_i,
   output preset_t            preset_o
);

   always_comb begin
      preset_o = '0;
      if (d1_i <= MAX_SEC_TENS) begin
         preset_o.min   = d2_i;
         preset_o.tens  = d1_i[TENS_W-1:0];
         preset_o.units = d0_i;
      end else if (d2_i < MAX_DIGIT) begin
         // Tens 6..9 becomes 0..3 after carrying one minute.
         preset_o.min   = d2_i + 4'd1;
         preset_o.tens  = TENS_W'(d1_i - 4'd6);
         preset_o.units = d0_i;
      end else begin
         preset_o.min   = MAX_DIGIT;
         preset_o.tens  = MAX_SEC_TENS[TENS_W-1:0];
         preset_o.units = MAX_DIGIT;
      end
   end

endmodule

// File: rtl/microwave_time_entry.sv
// -----------------------------------------------------------------------------
// microwave_time_entry
// Keypad-side writer for the MM:SS countdown timer. Collects up to
// MAX_DIGITS decimal digits (shifted in from the seconds-units end),
// normalises them on start, pulses load with the preset digits, holds the
// timer enable until timer_done, then beeps for BEEP_CYCLES cycles.
// Ports:
//   CLK, Reset           : clock (rising edge), async active-high reset
//   key_valid, key_code  : digit strobe and value (10-15 ignored)
//   start, clear         : one-cycle command strobes (clear > start > key)
//   timer_done           : timer at 0:00 (level, sampled only in RUNNING)
//   preset_sec_units/_sec_tens/_min_units : registered timer presets
//   load, enable, beep   : registered timer controls / completion indicator
//   state                : current FSM state (IDLE=0 .. DONE=4)
// -----------------------------------------------------------------------------
module microwave_time_entry
   import microwave_pkg::*;
#(
   parameter int BEEP_CYCLES = 3,
   parameter int MAX_DIGITS  = 3
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               key_valid,
   input  logic [3:0]         key_code,
   input  logic               start,
   input  logic               clear,
   input  logic               timer_done,
   output logic [3:0]         preset_sec_units,
   output logic [2:0]         preset_sec_tens,
   output logic [3:0]         preset_min_units,
   output logic               load,
   output logic               enable,
   output logic               beep,
   output logic [STATE_W-1:0] state
);

   localparam int BCW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
   localparam logic [BCW-1:0] BEEP_LAST = BCW'(BEEP_CYCLES - 1);
   localparam logic [1:0]     MAX_CNT   = 2'(MAX_DIGITS);

   logic [STATE_W-1:0] state_q, state_d;
   logic [DIGIT_W-1:0] d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
   logic [1:0]         cnt_q, cnt_d;
   preset_t            preset_q, preset_d;
   logic               load_q, load_d;
   logic               enable_q, enable_d;
   logic               beep_q, beep_d;
   logic [BCW-1:0]     beep_cnt_q, beep_cnt_d;

   preset_t norm;
   logic    key_ok;
   logic    entry_zero;
   logic    go_idle;

   time_normalizer u_norm (
      .d2_i     (d2_q),
      .d1_i     (d1_q),
      .d0_i     (d0_q),
      .preset_o (norm)
   );

   assign key_ok     = key_valid && is_digit(key_code) && (cnt_q < MAX_CNT);
   assign entry_zero = (d2_q == '0) && (d1_q == '0) && (d0_q == '0);

   always_comb begin
      state_d    = state_q;
      d2_d       = d2_q;
      d1_d       = d1_q;
      d0_d       = d0_q;
      cnt_d      = cnt_q;
      preset_d   = preset_q;
      beep_cnt_d = beep_cnt_q;
      go_idle    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // start with nothing keyed is meaningless; only a digit moves on.
            if (!clear && !start && key_ok) begin
               d2_d    = d1_q;
               d1_d    = d0_q;
               d0_d    = key_code;
               cnt_d   = cnt_q + 2'd1;
               state_d = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            if (clear) begin
               go_idle = 1'b1;
            end else if (start) begin
               // A 0:00 entry would load an already-expired timer; ignore it.
               if (!entry_zero) begin
                  preset_d = norm;
                  state_d  = ST_LOAD;
               end
            end else if (key_ok) begin
               d2_d  = d1_q;
               d1_d  = d0_q;
               d0_d  = key_code;
               cnt_d = cnt_q + 2'd1;
            end
         end
         ST_LOAD: begin
            if (clear) go_idle = 1'b1;
            else       state_d = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (clear) begin
               go_idle = 1'b1;
            end else if (timer_done) begin
               state_d    = ST_DONE;
               beep_cnt_d = BEEP_LAST;
            end
         end
         ST_DONE: begin
            // Down-counter reaches 0 on the last beep cycle.
            if (clear || (beep_cnt_q == '0)) go_idle = 1'b1;
            else                             beep_cnt_d = beep_cnt_q - 1'b1;
         end
         default: go_idle = 1'b1;
      endcase

      if (go_idle) begin
         state_d    = ST_IDLE;
         d2_d       = '0;
         d1_d       = '0;
         d0_d       = '0;
         cnt_d      = '0;
         preset_d   = '0;
         beep_cnt_d = '0;
      end

      // Controls are decoded from the next state so they are registered
      // and line up with the state they belong to.
      load_d   = (state_d == ST_LOAD);
      enable_d = (state_d == ST_RUNNING);
      beep_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         d2_q       <= '0;
         d1_q       <= '0;
         d0_q       <= '0;
         cnt_q      <= '0;
         preset_q   <= '0;
         load_q     <= 1'b0;
         enable_q   <= 1'b0;
         beep_q     <= 1'b0;
         beep_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         d2_q       <= d2_d;
         d1_q       <= d1_d;
         d0_q       <= d0_d;
         cnt_q      <= cnt_d;
         preset_q   <= preset_d;
         load_q     <= load_d;
         enable_q   <= enable_d;
         beep_q     <= beep_d;
         beep_cnt_q <= beep_cnt_d;
      end
   end

   assign preset_min_units = preset_q.min;
   assign preset_sec_tens  = preset_q.tens;
   assign preset_sec_units = preset_q.units;
   assign load             = load_q;
   assign enable           = enable_q;
   assign beep             = beep_q;
   assign state            = state_q;

endmodule

// File: tb/tb_microwave_time_entry.sv
// -----------------------------------------------------------------------------
// tb_microwave_time_entry
// Directed bench: a table of key sequences with hand-computed presets,
// followed by hand-written sequences for the full cook cycle, RUNNING
// corner cases, clear in LOAD/DONE and an asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_microwave_time_entry;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic       timer_done = 1'b0;
   logic [3:0] preset_sec_units;
   logic [2:0] preset_sec_tens;
   logic [3:0] preset_min_units;
   logic       load;
   logic       enable;
   logic       beep;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   microwave_time_entry #(.BEEP_CYCLES(3), .MAX_DIGITS(3)) dut (
      .CLK              (CLK),
      .Reset            (Reset),
      .key_valid        (key_valid),
      .key_code         (key_code),
      .start            (start),
      .clear            (clear),
      .timer_done       (timer_done),
      .preset_sec_units (preset_sec_units),
      .preset_sec_tens  (preset_sec_tens),
      .preset_min_units (preset_min_units),
      .load             (load),
      .enable           (enable),
      .beep             (beep),
      .state            (state)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int              nkeys;
      logic [3:0][3:0] keys;
      logic            exp_load;
      logic [2:0]      exp_state;
      logic [3:0]      exp_min;
      logic [2:0]      exp_tens;
      logic [3:0]      exp_units;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input int n, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d, input logic ld,
                               input logic [2:0] st, input logic [3:0] m,
                               input logic [2:0] t, input logic [3:0] u);
      vec_t v;
      v.nkeys     = n;
      v.keys      = {d, c, b, a};
      v.exp_load  = ld;
      v.exp_state = st;
      v.exp_min   = m;
      v.exp_tens  = t;
      v.exp_units = u;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      step();
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      step();
      key_valid = 1'b0;
   endtask

   task automatic press_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic press_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      //          n  k0    k1    k2    k3   load st  min   tens  units
      vecs[0]  = mk(3, 4'd1, 4'd3, 4'd0, 4'd0, 1, 2, 4'd1, 3'd3, 4'd0);
      vecs[1]  = mk(3, 4'd1, 4'd7, 4'd5, 4'd0, 1, 2, 4'd2, 3'd1, 4'd5);
      vecs[2]  = mk(3, 4'd9, 4'd9, 4'd9, 4'd0, 1, 2, 4'd9, 3'd5, 4'd9);
      vecs[3]  = mk(4, 4'd4, 4'd2, 4'd5, 4'd8, 1, 2, 4'd4, 3'd2, 4'd5);
      vecs[4]  = mk(4, 4'd4, 4'd12, 4'd2, 4'd5, 1, 2, 4'd4, 3'd2, 4'd5);
      vecs[5]  = mk(2, 4'd0, 4'd0, 4'd0, 4'd0, 0, 1, 4'd0, 3'd0, 4'd0);
      vecs[6]  = mk(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0, 3'd0, 4'd0);
      vecs[7]  = mk(2, 4'd6, 4'd0, 4'd0, 4'd0, 1, 2, 4'd1, 3'd0, 4'd0);
      vecs[8]  = mk(2, 4'd5, 4'd9, 4'd0, 4'd0, 1, 2, 4'd0, 3'd5, 4'd9);
      vecs[9]  = mk(3, 4'd8, 4'd9, 4'd9, 4'd0, 1, 2, 4'd9, 3'd3, 4'd9);
      vecs[10] = mk(2, 4'd9, 4'd9, 4'd0, 4'd0, 1, 2, 4'd1, 3'd3, 4'd9);

      #3;
      chk("reset_state",  32'(state), 0);
      chk("reset_load",   32'(load), 0);
      chk("reset_enable", 32'(enable), 0);
      chk("reset_beep",   32'(beep), 0);
      chk("reset_min",    32'(preset_min_units), 0);

      // ---------------- table-driven entry/normalisation ----------------
      for (int i = 0; i < NVEC; i++) begin
         do_reset();
         for (int j = 0; j < vecs[i].nkeys; j++) press(vecs[i].keys[j]);
         press_start();
         chk($sformatf("v%0d_load", i),  32'(load), 32'(vecs[i].exp_load));
         chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
         chk($sformatf("v%0d_min", i),   32'(preset_min_units), 32'(vecs[i].exp_min));
         chk($sformatf("v%0d_tens", i),  32'(preset_sec_tens), 32'(vecs[i].exp_tens));
         chk($sformatf("v%0d_units", i), 32'(preset_sec_units), 32'(vecs[i].exp_units));
         if (vecs[i].exp_load) begin
            step();
            chk($sformatf("v%0d_run_enable", i), 32'(enable), 1);
            chk($sformatf("v%0d_run_load", i),   32'(load), 0);
            chk($sformatf("v%0d_run_state", i),  32'(state), 3);
         end
      end

      // ---------------- full cook cycle 1:30 ----------------
      do_reset();
      press(4'd1);
      timer_done = 1'b1;   // ignored outside RUNNING
      press(4'd3);
      chk("entry_ignores_done", 32'(state), 1);
      timer_done = 1'b0;
      press(4'd0);
      press_start();
      chk("cook_load", 32'(load), 1);
      chk("cook_load_enable", 32'(enable), 0);
      step();
      chk("cook_enable", 32'(enable), 1);
      chk("cook_load_once", 32'(load), 0);
      step();
      chk("cook_enable_hold", 32'(enable), 1);
      timer_done = 1'b1;
      step();
      timer_done = 1'b0;
      chk("done_state", 32'(state), 4);
      chk("done_enable", 32'(enable), 0);
      chk("done_beep1", 32'(beep), 1);
      chk("done_preset_hold", 32'(preset_sec_tens), 3);
      step();
      chk("done_beep2", 32'(beep), 1);
      step();
      chk("done_beep3", 32'(beep), 1);
      step();
      chk("done_beep_off", 32'(beep), 0);
      chk("done_idle", 32'(state), 0);
      chk("done_preset_zero", 32'(preset_min_units), 0);

      // ---------------- RUNNING ignores keys/start; clear beats done ------
      do_reset();
      press(4'd2); press(4'd0); press(4'd0);
      press_start();
      step();
      press(4'd5);
      chk("run_key_state", 32'(state), 3);
      chk("run_key_min", 32'(preset_min_units), 2);
      chk("run_key_units", 32'(preset_sec_units), 0);
      press_start();
      chk("run_start_load", 32'(load), 0);
      chk("run_start_state", 32'(state), 3);
      clear = 1'b1;
      timer_done = 1'b1;
      step();
      clear = 1'b0;
      timer_done = 1'b0;
      chk("clrdone_state", 32'(state), 0);
      chk("clrdone_enable", 32'(enable), 0);
      chk("clrdone_beep", 32'(beep), 0);
      chk("clrdone_min", 32'(preset_min_units), 0);
      step();
      chk("clrdone_beep_later", 32'(beep), 0);

      // ---------------- clear in LOAD ----------------
      do_reset();
      press(4'd3);
      press_start();
      press_clear();
      chk("clrload_state", 32'(state), 0);
      chk("clrload_load", 32'(load), 0);
      chk("clrload_enable", 32'(enable), 0);

      // ---------------- clear in DONE ----------------
      do_reset();
      press(4'd7);
      press_start();
      step();
      timer_done = 1'b1;
      step();
      timer_done = 1'b0;
      chk("clrdone2_pre_beep", 32'(beep), 1);
      press_clear();
      chk("clrdone2_state", 32'(state), 0);
      chk("clrdone2_beep", 32'(beep), 0);

      // ---------------- async reset mid-RUNNING ----------------
      do_reset();
      press(4'd1); press(4'd5);
      press_start();
      step();
      chk("arst_pre_enable", 32'(enable), 1);
      #3;
      Reset = 1'b1;
      #1;
      chk("arst_enable", 32'(enable), 0);
      chk("arst_load", 32'(load), 0);
      chk("arst_beep", 32'(beep), 0);
      chk("arst_tens", 32'(preset_sec_tens), 0);
      chk("arst_state", 32'(state), 0);
      #2;
      Reset = 1'b0;
      step();
      chk("arst_after_state", 32'(state), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
